// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback path: widths, the
// writeback request record and the hard-wired zero register.
package rf_wb_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_sync_fifo.sv
// Small synchronous FIFO; storage is left unreset, only pointers and the
// occupancy count are cleared.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH[PW:0]);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, queued
// multi-cycle results fill idle cycles, plus a pending-destination scoreboard.
module rf_wb_arbiter #(
  parameter int DATA_W     = rf_wb_arbiter_pkg::DATA_W,
  parameter int ADDR_W     = rf_wb_arbiter_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_we,
  input  logic [ADDR_W-1:0]    pipe_wa,
  input  logic [DATA_W-1:0]    pipe_wd,
  input  logic                 mc_valid,
  output logic                 mc_ready,
  input  logic [ADDR_W-1:0]    mc_wa,
  input  logic [DATA_W-1:0]    mc_wd,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_wa,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_wa,
  output logic [DATA_W-1:0]    rf_wd,
  output logic [2**ADDR_W-1:0] busy_vec,
  output logic                 pipe_stall,
  output logic                 waw_err
);

  import rf_wb_arbiter_pkg::*;

  localparam int NREG = 2**ADDR_W;
  localparam int SW   = $clog2(STARVE_MAX + 1);

  logic                        pipe_hit;
  logic                        push;
  logic                        pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [ADDR_W-1:0]           head_wa;
  logic [DATA_W-1:0]           head_wd;
  logic [NREG-1:0]             set_mask;
  logic [NREG-1:0]             clr_mask;
  logic [SW-1:0]               starve_cnt;
  wb_req_t                     wr;

  assign pipe_hit = pipe_we && (pipe_wa != REG_ZERO);
  assign pop      = !pipe_hit && !fifo_empty;
  assign mc_ready = !rst && !fifo_full;
  // Results aimed at x0 are handshaken but never stored.
  assign push     = mc_valid && mc_ready && (mc_wa != REG_ZERO);

  sync_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({mc_wa, mc_wd}),
    .dout  ({head_wa, head_wd}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    wr = '0;
    if (!rst) begin
      if (pipe_hit)         wr = '{we: 1'b1, wa: pipe_wa, wd: pipe_wd};
      else if (!fifo_empty) wr = '{we: 1'b1, wa: head_wa, wd: head_wd};
    end
  end

  assign rf_we = wr.we;
  assign rf_wa = wr.wa;
  assign rf_wd = wr.wd;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && (issue_wa != REG_ZERO)) set_mask[issue_wa] = 1'b1;
    if (pop)                                   clr_mask[head_wa]  = 1'b1;
  end

  // Set is OR'd in after the clear so a same-cycle issue keeps the bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_vec <= '0;
    else     busy_vec <= (busy_vec & ~clr_mask) | set_mask;
  end

  // With the FIFO occupied and no pop, the pipeline necessarily won the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
      waw_err    <= 1'b0;
    end else begin
      pipe_stall <= 1'b0;
      if (pop || (fifo_count == '0)) begin
        starve_cnt <= '0;
      end else if (starve_cnt == SW'(STARVE_MAX - 1)) begin
        starve_cnt <= '0;
        pipe_stall <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      if (pipe_hit && busy_vec[pipe_wa]) waw_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, hand-built multi-cycle
// sequences and a randomized run against a queue-based reference model.
module tb_rf_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_wa = '0;
  logic [31:0] pipe_wd = '0;
  logic        mc_valid = 1'b0;
  logic        mc_ready;
  logic [4:0]  mc_wa = '0;
  logic [31:0] mc_wd = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_wa = '0;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] busy_vec;
  logic        pipe_stall;
  logic        waw_err;

  rf_wb_arbiter #(
    .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_wa(mc_wa), .mc_wd(mc_wd),
    .issue_valid(issue_valid), .issue_wa(issue_wa),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .busy_vec(busy_vec), .pipe_stall(pipe_stall), .waw_err(waw_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drv(input bit pw, input int pa, input int pd, input bit mv,
                     input int ma, input int md, input bit iv, input int ia);
    pipe_we = pw; pipe_wa = 5'(pa); pipe_wd = 32'(pd);
    mc_valid = mv; mc_wa = 5'(ma); mc_wd = 32'(md);
    issue_valid = iv; issue_wa = 5'(ia);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: pending results in arrival order, pending bits.
  typedef struct { logic [4:0] wa; logic [31:0] wd; } ent_t;
  ent_t        q[$];
  logic [31:0] m_busy;
  int          m_starve;
  bit          m_stall;
  bit          m_waw;

  task automatic do_reset();
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_busy = '0; m_starve = 0; m_stall = 0; m_waw = 0;
  endtask

  task automatic model_check(input string nm);
    bit          hit;
    logic [37:0] ep;
    hit = pipe_we && (pipe_wa != 0);
    if (hit)              ep = {1'b1, pipe_wa, pipe_wd};
    else if (q.size() > 0) ep = {1'b1, q[0].wa, q[0].wd};
    else                  ep = '0;
    chk({nm, " port"}, {rf_we, rf_wa, rf_wd}, ep);
    chk({nm, " state"}, {mc_ready, busy_vec, pipe_stall, waw_err},
        {(q.size() < DEPTH), m_busy, m_stall, m_waw});
  endtask

  task automatic model_step();
    bit   hit, was_empty, popped;
    ent_t e;
    hit       = pipe_we && (pipe_wa != 0);
    was_empty = (q.size() == 0);
    popped    = !hit && !was_empty;
    if (hit && m_busy[pipe_wa]) m_waw = 1;
    if (mc_valid && q.size() < DEPTH && mc_wa != 0) begin
      e.wa = mc_wa; e.wd = mc_wd;
      q.push_back(e);
    end
    if (popped) begin
      m_busy[q[0].wa] = 1'b0;
      void'(q.pop_front());
    end
    if (issue_valid && issue_wa != 0) m_busy[issue_wa] = 1'b1;
    m_stall = 0;
    if (popped || was_empty) m_starve = 0;
    else begin
      m_starve++;
      if (m_starve == SMAX) begin m_stall = 1; m_starve = 0; end
    end
  endtask

  typedef struct {
    int pw, pa, pd, mv, ma, md, iv, ia;
    int e_we, e_wa, e_wd, e_rdy, e_busy, e_stall, e_waw;
    string name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Pipeline request during reset must not reach the register file.
    drv(1, 3, 32'h77, 1, 4, 1, 1, 4);
    #2;
    chk("reset state", {rf_we, mc_ready, busy_vec, pipe_stall, waw_err}, '0);

    // pw pa pd | mv ma md | iv ia || we wa wd | rdy busy stall waw
    tbl.push_back(vec_t'{0,0,0,          0,0,0,          1,5, 0,0,0,          1,32'h0,0,0,   "issue x5"});
    tbl.push_back(vec_t'{0,0,0,          1,5,32'h1234,   0,0, 0,0,0,          1,32'h20,0,0,  "push x5"});
    tbl.push_back(vec_t'{0,0,0,          0,0,0,          0,0, 1,5,32'h1234,   1,32'h20,0,0,  "idle drain x5"});
    tbl.push_back(vec_t'{0,0,0,          0,0,0,          0,0, 0,0,0,          1,32'h0,0,0,   "x5 retired"});
    tbl.push_back(vec_t'{0,0,0,          0,0,0,          1,6, 0,0,0,          1,32'h0,0,0,   "issue x6"});
    tbl.push_back(vec_t'{1,7,32'hBB,     1,6,32'hAA,     0,0, 1,7,32'hBB,     1,32'h40,0,0,  "pipe x7 push x6"});
    tbl.push_back(vec_t'{1,7,32'hBB,     0,0,0,          0,0, 1,7,32'hBB,     1,32'h40,0,0,  "pipe beats head"});
    tbl.push_back(vec_t'{0,0,0,          0,0,0,          0,0, 1,6,32'hAA,     1,32'h40,0,0,  "x6 in gap"});
    tbl.push_back(vec_t'{0,0,0,          0,0,0,          0,0, 0,0,0,          1,32'h0,0,0,   "x6 retired"});
    tbl.push_back(vec_t'{0,0,0,          1,0,32'hDEAD,   0,0, 0,0,0,          1,32'h0,0,0,   "mc to x0"});
    tbl.push_back(vec_t'{0,0,0,          0,0,0,          0,0, 0,0,0,          1,32'h0,0,0,   "x0 not written"});
    tbl.push_back(vec_t'{0,0,0,          0,0,0,          1,9, 0,0,0,          1,32'h0,0,0,   "issue x9"});
    tbl.push_back(vec_t'{0,0,0,          1,9,32'h99,     0,0, 0,0,0,          1,32'h200,0,0, "push x9"});
    tbl.push_back(vec_t'{0,0,0,          0,0,0,          1,9, 1,9,32'h99,     1,32'h200,0,0, "retire+issue x9"});
    tbl.push_back(vec_t'{0,0,0,          0,0,0,          0,0, 0,0,0,          1,32'h200,0,0, "set wins x9"});
    tbl.push_back(vec_t'{1,9,32'h55,     0,0,0,          0,0, 1,9,32'h55,     1,32'h200,0,0, "pipe to busy x9"});
    tbl.push_back(vec_t'{0,0,0,          0,0,0,          0,0, 0,0,0,          1,32'h200,0,1, "waw set"});
    tbl.push_back(vec_t'{1,0,32'h77,     0,0,0,          0,0, 0,0,0,          1,32'h200,0,1, "pipe x0 sticky waw"});

    do_reset();
    foreach (tbl[i]) begin
      drv(tbl[i].pw[0], tbl[i].pa, tbl[i].pd, tbl[i].mv[0], tbl[i].ma, tbl[i].md,
          tbl[i].iv[0], tbl[i].ia);
      #3;
      chk({tbl[i].name, " port"}, {rf_we, rf_wa, rf_wd},
          {1'(tbl[i].e_we), 5'(tbl[i].e_wa), 32'(tbl[i].e_wd)});
      chk({tbl[i].name, " state"}, {mc_ready, busy_vec, pipe_stall, waw_err},
          {1'(tbl[i].e_rdy), 32'(tbl[i].e_busy), 1'(tbl[i].e_stall), 1'(tbl[i].e_waw)});
      step();
    end

    // FIFO full: third result is held back and drains after the first two.
    do_reset();
    drv(1, 1, 32'h11, 1, 10, 32'hA0, 0, 0); #3; chk("full c0 ready", mc_ready, 1); step();
    drv(1, 1, 32'h11, 1, 11, 32'hA1, 0, 0); #3; chk("full c1 ready", mc_ready, 1); step();
    drv(1, 1, 32'h11, 1, 12, 32'hA2, 0, 0); #3; chk("full c2 ready", mc_ready, 0); step();
    drv(0, 0, 0,      1, 12, 32'hA2, 0, 0); #3;
    chk("full c3", {mc_ready, rf_we, rf_wa, rf_wd}, {1'b0, 1'b1, 5'd10, 32'hA0}); step();
    #3; chk("full c4", {mc_ready, rf_we, rf_wa, rf_wd}, {1'b1, 1'b1, 5'd11, 32'hA1}); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0); #3;
    chk("full c5 held", {rf_we, rf_wa, rf_wd}, {1'b1, 5'd12, 32'hA2}); step();
    #3; chk("full c6 empty", rf_we, 0); step();

    // Starvation: four blocked cycles force a one-cycle stall.
    do_reset();
    drv(1, 1, 32'h11, 1, 3, 32'hC3, 0, 0); step();
    drv(1, 1, 32'h11, 0, 0, 0, 0, 0);
    for (int i = 1; i <= SMAX; i++) begin
      #3; chk($sformatf("starve blocked %0d", i), {pipe_stall, rf_wa}, {1'b0, 5'd1}); step();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0); #3;
    chk("starve stall", {pipe_stall, rf_we, rf_wa, rf_wd}, {1'b1, 1'b1, 5'd3, 32'hC3}); step();
    #3; chk("starve after", {pipe_stall, rf_we}, 0); step();

    // Reset asserted with two queued results and x5/x6 pending.
    do_reset();
    drv(1, 1, 32'h11, 0, 0, 0, 1, 5); step();
    drv(1, 1, 32'h11, 1, 5, 32'h1, 1, 6); step();
    drv(1, 1, 32'h11, 1, 6, 32'h2, 0, 0); step();
    drv(1, 1, 32'h11, 0, 0, 0, 0, 0); #3;
    chk("midop before rst", {mc_ready, busy_vec}, {1'b0, 32'h60});
    #1; rst = 1'b1; #1;
    chk("midop in rst", {rf_we, mc_ready, busy_vec}, '0);
    @(posedge clk); #1; rst = 1'b0; pipe_we = 1'b0; #3;
    chk("midop released", {mc_ready, rf_we, busy_vec}, {1'b1, 1'b0, 32'h0}); step();

    // Randomized run against the reference model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      pipe_we     = m_stall ? 1'b0 : ($urandom_range(0, 9) < 6);
      pipe_wa     = 5'($urandom_range(0, 31));
      pipe_wd     = $urandom;
      mc_valid    = 1'($urandom_range(0, 1));
      mc_wa       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mc_wd       = $urandom;
      issue_valid = ($urandom_range(0, 9) < 3);
      issue_wa    = 5'($urandom_range(0, 31));
      #3;
      model_check($sformatf("rand %0d", c));
      model_step();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between two requesters: the in-order pipeline writeback (WB) stage and a multi-cycle execution unit (MUL/DIV, long-latency load).
- The pipeline has absolute priority. Multi-cycle results queue in a small FIFO and drain into idle write-port cycles.
- Holds a pending-destination scoreboard that the hazard unit uses.
- Sits between the WB stage / multi-cycle unit and the register file, driving its we/wa/wd.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width (32 registers)
FIFO_DEPTH, 2, multi-cycle result queue entries (power of 2, >=2)
STARVE_MAX, 4, consecutive blocked cycles before a pipeline WB bubble is forced (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
pipe_we  in  1  WB stage write request
pipe_wa  in  ADDR_W  WB destination
pipe_wd  in  DATA_W  WB data
mc_valid  in  1  multi-cycle result valid
mc_ready  out  1  FIFO can accept a result
mc_wa  in  ADDR_W  result destination
mc_wd  in  DATA_W  result data
issue_valid  in  1  a multi-cycle op is issued this cycle
issue_wa  in  ADDR_W  destination of the issued op
rf_we  out  1  register file write enable
rf_wa  out  ADDR_W  register file write address
rf_wd  out  DATA_W  register file write data
busy_vec  out  2**ADDR_W  pending multi-cycle destinations, bit i = register i
pipe_stall  out  1  pipeline must not present a WB write next cycle
waw_err  out  1  sticky: pipeline wrote a busy register

Behaviour:
Reset (async, rst=1):
- FIFO emptied; busy_vec=0; starvation counter=0; pipe_stall=0; waw_err=0.
- rf_we forced 0 while rst=1; mc_ready=0 while rst=1.

Write-port mux (combinational, zero latency):
- pipe_we=1 and pipe_wa!=0 (pipe_hit): rf_we=1, rf_wa=pipe_wa, rf_wd=pipe_wd.
- Else, if the FIFO is non-empty: rf_we=1, rf_wa/rf_wd = head entry, and the head is popped at the clock edge.
- Else: rf_we=0. rf_wa and rf_wd are don't-care; drive 0.
- A pipeline write to x0 does not occupy the port.

FIFO:
- mc_ready = !full, derived from registered count only. No push-at-full, even if a pop happens the same cycle.
- Push on mc_valid && mc_ready. An entry with mc_wa==0 is accepted but discarded (no push).
- Push and pop may occur in the same cycle. Count is unchanged; pointers wrap modulo FIFO_DEPTH.
- Minimum result-to-RF latency is 1 cycle; results drain in arrival order.

Scoreboard:
- issue_valid && issue_wa!=0 sets busy_vec[issue_wa] at the edge.
- A FIFO pop clears busy_vec[head.wa].
- Set and clear of the same bit in the same cycle: set wins.
- Re-issue to an already-busy register is illegal (the hazard unit prevents it). If it happens, the bit clears at the first retirement.
- busy_vec is registered and reflects state after the edge.

Starvation:
- The counter increments each cycle that the FIFO is non-empty and pipe_hit=1. It clears on any pop or when the FIFO is empty.
- When the counter reaches STARVE_MAX, pipe_stall is registered high for exactly one cycle and the counter clears.
- The pipeline guarantees pipe_we=0 in the cycle after pipe_stall, so that cycle pops the head.

waw_err:
- Set when pipe_hit && busy_vec[pipe_wa]=1. Cleared only by reset.

Decomposition:
- Shared package: DATA_W/ADDR_W constants, a wb_req_t struct {we, wa, wd} used by the WB stage and the arbiter, and the REG_ZERO constant.
- One natural sub-module: sync_fifo (parameterised width/depth, full/empty/count). It holds {wa, wd}.
- The scoreboard, starvation counter and mux stay in the top level.

Test Plan:
- Reset mid-operation: FIFO holding 2 entries, busy_vec=0x0000_0060, assert rst -> same cycle rf_we=0, mc_ready=0, busy_vec=0; after release mc_ready=1.
- Idle drain: issue x5, then mc_valid with wa=5, wd=0x1234 while pipe_we=0 -> next cycle rf_we=1, rf_wa=5, rf_wd=0x1234; busy_vec[5] clears after that edge.
- Priority: FIFO head x6=0xAA and pipe writes x7=0xBB -> rf_wa=7, rf_wd=0xBB; x6 written the first cycle with pipe_we=0.
- Full: 2 results pushed while pipe writes every cycle -> mc_ready=0; a third mc_valid is held and not lost; mc_ready returns to 1 after the first pop.
- Starvation (STARVE_MAX=4): FIFO non-empty, pipe writes continuously -> pipe_stall=1 for one cycle after the 4th blocked cycle; the next cycle drains the head.
- Edges: mc_wa=0 is accepted and never written to the RF; issue and retire of x9 in the same cycle leaves busy_vec[9]=1; a pipe write to busy x9 sets waw_err=1 and it stays 1.
